// File: rtl/dmem_pkg.sv
// Shared types for the cache miss/writeback interface and the main-memory responder.
package dmem_pkg;

  localparam int DMEM_LINE_BITS   = 128;
  localparam int DMEM_ADDR_BITS   = 32;
  localparam int LINE_BYTES       = DMEM_LINE_BITS / 8;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

  typedef logic [DMEM_LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                      write;
    logic [DMEM_ADDR_BITS-1:0] addr;
    line_t                     wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_latency_timer.sv
// Loadable down-counter; done is high for exactly one cycle when a loaded count reaches zero.
module dmem_latency_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;
  logic             armed;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= load_value;
      armed <= 1'b1;
    end else if (armed) begin
      if (count == '0) armed <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

  // armed keeps an idle counter at zero from producing spurious done pulses
  assign done = armed && (count == '0);

endmodule

// File: rtl/dmem_line_responder.sv
// Main-memory line responder: one fill or writeback at a time, fixed access latency,
// response returned over a valid/ready handshake.
//
// state | meaning
// IDLE  | req_ready high, waiting for a transaction
// WAIT  | access latency running, request latched
// RESP  | resp_valid high, holding data until resp_ready
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LINE_BITS   = DMEM_LINE_BITS,
  parameter int ADDR_BITS   = DMEM_ADDR_BITS,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LINE_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_write,
  output logic [LINE_BITS-1:0] resp_rdata,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int IDX_BITS = $clog2(DEPTH_LINES);
  localparam logic [7:0] LOAD_VALUE = 8'(LATENCY - 1);

  logic [LINE_BITS-1:0] memArray [0:DEPTH_LINES-1];

  mem_state_e           state;
  logic                 lat_write;
  logic [IDX_BITS-1:0]  lat_idx;
  logic [LINE_BITS-1:0] lat_wdata;

  logic                 accept;
  logic                 timer_load;
  logic                 timer_done;
  logic                 commit;
  logic                 c_write;
  logic [IDX_BITS-1:0]  c_idx;
  logic [LINE_BITS-1:0] c_wdata;
  logic [IDX_BITS-1:0]  req_idx;
  logic                 addr_unused;

  assign req_idx     = req_addr[OFF_BITS +: IDX_BITS];
  assign addr_unused = ^{req_addr[ADDR_BITS-1:OFF_BITS+IDX_BITS], req_addr[OFF_BITS-1:0]};

  assign accept     = (state == IDLE) && req_valid && req_ready;
  assign timer_load = accept && (LATENCY > 1);

  dmem_latency_timer #(
    .WIDTH(8)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (timer_load),
    .load_value(LOAD_VALUE),
    .done      (timer_done)
  );

  // With LATENCY==1 the access completes on the accept edge, straight from the request bus
  always_comb begin
    commit  = 1'b0;
    c_write = lat_write;
    c_idx   = lat_idx;
    c_wdata = lat_wdata;
    if (state == IDLE) begin
      commit  = accept && (LATENCY == 1);
      c_write = req_write;
      c_idx   = req_idx;
      c_wdata = req_wdata;
    end else if (state == WAIT) begin
      commit  = timer_done;
    end
  end

  // Storage is not reset; a write still in WAIT when reset hits is simply never committed
  always_ff @(posedge clock) begin
    if (reset && commit && c_write) memArray[c_idx] <= c_wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
      lat_write  <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (LATENCY == 1) state <= RESP;
            else              state <= WAIT;
          end
        end
        WAIT: begin
          if (timer_done) state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase

      if (commit) begin
        resp_valid <= 1'b1;
        resp_write <= c_write;
        resp_rdata <= c_write ? c_wdata : memArray[c_idx];
        if (c_write) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Bench for dmem_line_responder: a LATENCY=5 instance for the main checks and a
// LATENCY=1 instance for back-to-back timing.
module tb_dmem_line_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 5;

  localparam line_t MEM0  = 128'd5;
  localparam line_t MEM1  = {4{32'hA5A5_0001}};
  localparam line_t MEM2  = {4{32'h2222_2222}};
  localparam line_t MEM3  = {4{32'h3333_0003}};
  localparam line_t WC    = {4{32'h0000_000C}};
  localparam line_t WTOP  = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hFEED_F00D};
  localparam line_t WX    = {4{32'hBAD0_BAD0}};
  localparam line_t W3    = {32'h1, 32'h2, 32'h3, 32'h4};
  localparam line_t B4    = {4{32'h4444_0004}};
  localparam line_t B5    = {4{32'h5555_0005}};

  logic        clock = 1'b0;
  logic        reset, reset1;
  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_write;
  logic [31:0] req_addr;
  line_t       req_wdata, resp_rdata;
  logic [15:0] rd_count, wr_count;

  logic        l1_req_valid, l1_req_ready, l1_req_write, l1_resp_valid, l1_resp_ready, l1_resp_write;
  logic [31:0] l1_req_addr;
  line_t       l1_req_wdata, l1_resp_rdata;
  logic [15:0] l1_rd_count, l1_wr_count;

  always #5 clock = ~clock;

  dmem_line_responder #(.DEPTH_LINES(DEPTH), .LATENCY(LAT)) dut5 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .rd_count(rd_count), .wr_count(wr_count)
  );

  dmem_line_responder #(.DEPTH_LINES(DEPTH), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset1),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
    .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready), .resp_write(l1_resp_write),
    .resp_rdata(l1_resp_rdata), .rd_count(l1_rd_count), .wr_count(l1_wr_count)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic write;
    line_t rdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        write;
    logic [31:0] addr;
    line_t       wdata;
    line_t       exp_rdata;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
    string       name;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one request on the LATENCY=5 instance, returns once resp_valid is seen
  task automatic run_txn(input logic write, input logic [31:0] addr, input line_t wdata,
                         input line_t exp_rdata, input string name);
    int   n;
    exp_t e;
    check({name, ":req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    sb_q.push_back('{write, exp_rdata});
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 30) begin
      tick();
      n++;
    end
    check({name, ":latency"}, n, LAT);
    if (resp_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, ":rdata"}, resp_rdata, e.rdata);
      check({name, ":resp_write"}, resp_write, e.write);
    end
  endtask

  task automatic finish_resp(input string name);
    resp_ready = 1'b1;
    tick();
    check({name, ":valid_drop"}, resp_valid, 1'b0);
    check({name, ":ready_rise"}, req_ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0000, '0,   MEM0, 16'd1, 16'd0, "fill0"};
    vecs[1] = '{1'b1, 32'h0000_000C, WC,   WC,   16'd1, 16'd1, "wb_0xC"};
    vecs[2] = '{1'b0, 32'h0000_0004, '0,   WC,   16'd2, 16'd1, "fill_0x4"};
    vecs[3] = '{1'b0, 32'h0000_4010, '0,   MEM1, 16'd3, 16'd1, "wrap"};
    vecs[4] = '{1'b1, 32'h0000_3FF0, WTOP, WTOP, 16'd3, 16'd2, "wb_top"};
    vecs[5] = '{1'b0, 32'h0000_3FFC, '0,   WTOP, 16'd4, 16'd2, "fill_top"};

    reset = 1'b0; reset1 = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = '0; l1_req_wdata = '0; l1_resp_ready = 1'b1;
    dut5.memArray[0] = MEM0;
    dut5.memArray[1] = MEM1;
    dut5.memArray[2] = MEM2;
    dut5.memArray[3] = MEM3;
    dut1.memArray[4] = B4;
    dut1.memArray[5] = B5;

    repeat (3) tick();
    check("rst:req_ready", req_ready, 1'b1);
    check("rst:resp_valid", resp_valid, 1'b0);
    check("rst:resp_write", resp_write, 1'b0);
    check("rst:resp_rdata", resp_rdata, '0);
    check("rst:rd_count", rd_count, 16'd0);
    check("rst:wr_count", wr_count, 16'd0);
    reset = 1'b1; reset1 = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].name);
      finish_resp(vecs[i].name);
      check({vecs[i].name, ":rd_count"}, rd_count, vecs[i].exp_rd);
      check({vecs[i].name, ":wr_count"}, wr_count, vecs[i].exp_wr);
    end

    // Backpressure: response held while a competing write request is presented
    resp_ready = 1'b0;
    run_txn(1'b0, 32'h0000_0010, '0, MEM1, "bp");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = '1;
    for (int c = 0; c < 7; c++) begin
      tick();
      check("bp:hold_valid", resp_valid, 1'b1);
      check("bp:hold_rdata", resp_rdata, MEM1);
      check("bp:req_ready_low", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    finish_resp("bp");
    check("bp:mem2_untouched", dut5.memArray[2], MEM2);
    check("bp:rd_count", rd_count, 16'd5);
    check("bp:wr_count", wr_count, 16'd2);

    // Reset two cycles into the latency window of a write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = WX;
    tick();
    req_valid = 1'b0;
    check("rstwait:in_wait", req_ready, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rstwait:resp_valid", resp_valid, 1'b0);
    check("rstwait:req_ready", req_ready, 1'b1);
    repeat (8) tick();
    check("rstwait:no_late_resp", resp_valid, 1'b0);
    check("rstwait:mem2", dut5.memArray[2], MEM2);
    check("rstwait:wr_count", wr_count, 16'd0);

    // Reset while a committed write sits in RESP
    resp_ready = 1'b0;
    run_txn(1'b1, 32'h0000_0030, W3, W3, "rstresp");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    resp_ready = 1'b1;
    tick();
    check("rstresp:resp_valid", resp_valid, 1'b0);
    check("rstresp:mem3", dut5.memArray[3], W3);
    run_txn(1'b0, 32'h0000_0038, '0, W3, "rstresp_fill");
    finish_resp("rstresp_fill");
    check("rstresp:rd_count", rd_count, 16'd1);
    check("sb:empty", sb_q.size(), 0);

    // LATENCY=1: back-to-back fills with req_valid held high throughout
    l1_req_valid = 1'b1; l1_req_write = 1'b0; l1_req_addr = 32'h40;
    check("b2b:ready0", l1_req_ready, 1'b1);
    tick();
    check("b2b:valid_a", l1_resp_valid, 1'b1);
    check("b2b:rdata_a", l1_resp_rdata, B4);
    check("b2b:ready_low", l1_req_ready, 1'b0);
    l1_req_addr = 32'h50;
    tick();
    check("b2b:hs_valid", l1_resp_valid, 1'b0);
    check("b2b:hs_ready", l1_req_ready, 1'b1);
    tick();
    check("b2b:valid_b", l1_resp_valid, 1'b1);
    check("b2b:rdata_b", l1_resp_rdata, B5);
    l1_req_valid = 1'b0;
    tick();
    check("b2b:done_valid", l1_resp_valid, 1'b0);
    check("b2b:rd_count", l1_rd_count, 16'd2);
    check("b2b:wr_count", l1_wr_count, 16'd0);
    check("b2b:resp_write", l1_resp_write, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
